// File: rtl/board_pkg.sv
// Shared types and constants for the board renderer: FSM states, colours, coordinate width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package board_pkg;

  // Renderer sequencing states
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAW  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Player coordinates arrive as one nibble per axis per player
  localparam int COORD_W = 4;

  // 3-bit RGB palette
  localparam logic [2:0] GRID_COLOUR = 3'b000;
  localparam logic [2:0] WHITE       = 3'b111;
  localparam logic [2:0] RED         = 3'b100;
  localparam logic [2:0] BLUE        = 3'b001;

endpackage

// File: rtl/board_renderer_tile_counter.sv
// Pixel/cell scan counters: px fastest, then py, then col, then row, all wrapping to zero.
// Latency: counters advance on the edge where step is high; flags are combinational.
// Backpressure: none; the counters only move when step is asserted.
module tile_counter
  import board_pkg::*;
#(
  parameter int COLS = 8,
  parameter int ROWS = 8,
  parameter int TILE = 16,
  localparam int PX_W = $clog2(TILE)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               clear,
  input  logic               step,
  output logic [PX_W-1:0]    px,
  output logic [PX_W-1:0]    py,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               tile_last,
  output logic               frame_last
);

  logic px_last;
  logic py_last;
  logic col_last;
  logic row_last;

  assign px_last    = (px == PX_W'(TILE - 1));
  assign py_last    = (py == PX_W'(TILE - 1));
  assign col_last   = (col == COORD_W'(COLS - 1));
  assign row_last   = (row == COORD_W'(ROWS - 1));
  assign tile_last  = px_last && py_last;
  assign frame_last = tile_last && col_last && row_last;

  // Nested wrap counters; the whole chain returns to zero after the last pixel of the last cell
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      px  <= '0;
      py  <= '0;
      col <= '0;
      row <= '0;
    end else if (clear) begin
      px  <= '0;
      py  <= '0;
      col <= '0;
      row <= '0;
    end else if (step) begin
      px <= px_last ? '0 : px + 1'b1;
      if (px_last) begin
        py <= py_last ? '0 : py + 1'b1;
      end
      if (tile_last) begin
        col <= col_last ? '0 : col + 1'b1;
      end
      if (tile_last && col_last) begin
        row <= row_last ? '0 : row + 1'b1;
      end
    end
  end

endmodule

// File: rtl/board_renderer.sv
// Renders a COLS x ROWS board of TILE-pixel cells to a VGA adapter, with per-player cell overlays.
// Latency: each cell costs 2 fetch cycles plus TILE*TILE plot cycles; done one cycle after the last plot.
// Backpressure: none; start is accepted only in IDLE and ignored while busy. Optional BOARD_GRID_EN draws grid lines.
module board_renderer
  import board_pkg::*;
#(
  parameter int COLS        = 8,
  parameter int ROWS        = 8,
  parameter int TILE        = 16,
  parameter int X_ORIGIN    = 32,
  parameter int Y_ORIGIN    = 8,
  parameter int NUM_PLAYERS = 2,
  parameter int COLOUR_W    = 3,
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  localparam int ADDR_W     = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic                            clock,
  input  logic                            resetn,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic                            mem_rden,
  input  logic [COLOUR_W-1:0]             mem_q,
  input  logic [COORD_W*NUM_PLAYERS-1:0]  player_x,
  input  logic [COORD_W*NUM_PLAYERS-1:0]  player_y,
  input  logic [COLOUR_W*NUM_PLAYERS-1:0] player_colour,
  output logic [X_W-1:0]                  x,
  output logic [Y_W-1:0]                  y,
  output logic [COLOUR_W-1:0]             colour,
  output logic                            plot
);

  localparam int PX_W = $clog2(TILE);

  state_t state;
  state_t state_next;

  logic                            accept;
  logic                            drawing;
  logic [PX_W-1:0]                 px;
  logic [PX_W-1:0]                 py;
  logic [COORD_W-1:0]              col;
  logic [COORD_W-1:0]              row;
  logic                            tile_last;
  logic                            frame_last;

  logic [COORD_W*NUM_PLAYERS-1:0]  snap_x;
  logic [COORD_W*NUM_PLAYERS-1:0]  snap_y;
  logic [COLOUR_W*NUM_PLAYERS-1:0] snap_colour;
  logic [COLOUR_W-1:0]             overlay_colour;
  logic [COLOUR_W-1:0]             cell_colour;
  logic [COLOUR_W-1:0]             pixel_colour;
  logic [X_W-1:0]                  x_calc;
  logic [Y_W-1:0]                  y_calc;
  logic [X_W-1:0]                  x_hold;
  logic [Y_W-1:0]                  y_hold;
  logic [COLOUR_W-1:0]             colour_hold;

  assign accept  = (state == S_IDLE) && start;
  assign drawing = (state == S_DRAW);

  tile_counter #(
    .COLS (COLS),
    .ROWS (ROWS),
    .TILE (TILE)
  ) u_scan (
    .clock      (clock),
    .resetn     (resetn),
    .clear      (accept),
    .step       (drawing),
    .px         (px),
    .py         (py),
    .col        (col),
    .row        (row),
    .tile_last  (tile_last),
    .frame_last (frame_last)
  );

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: one fetch/wait pair per cell, then the tile's pixels, then back for the next cell
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: state_next = S_WAIT;
      S_WAIT:  state_next = S_DRAW;
      S_DRAW: begin
        if (frame_last)     state_next = S_DONE;
        else if (tile_last) state_next = S_FETCH;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Player inputs are frozen at frame start so mid-frame moves cannot tear the image
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      snap_x      <= '0;
      snap_y      <= '0;
      snap_colour <= '0;
    end else if (accept) begin
      snap_x      <= player_x;
      snap_y      <= player_y;
      snap_colour <= player_colour;
    end
  end

  // Overlay: walk players from highest to lowest index so the lowest matching index wins.
  // col/row never reach COLS/ROWS, so off-board player coordinates can never match.
  always_comb begin
    overlay_colour = mem_q;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if ((snap_x[i*COORD_W +: COORD_W] == col) && (snap_y[i*COORD_W +: COORD_W] == row)) begin
        overlay_colour = snap_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  // Capture the memory read (valid during WAIT) with the overlay already resolved
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cell_colour <= '0;
    end else if (state == S_WAIT) begin
      cell_colour <= overlay_colour;
    end
  end

  assign x_calc = X_W'(32'(X_ORIGIN) + 32'(col) * 32'(TILE) + 32'(px));
  assign y_calc = Y_W'(32'(Y_ORIGIN) + 32'(row) * 32'(TILE) + 32'(py));

`ifdef BOARD_GRID_EN
  assign pixel_colour = ((px == '0) || (py == '0)) ? COLOUR_W'(GRID_COLOUR) : cell_colour;
`else
  assign pixel_colour = cell_colour;
`endif

  // Remember the last plotted pixel so the adapter outputs stay put between tiles and frames
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x_hold      <= '0;
      y_hold      <= '0;
      colour_hold <= '0;
    end else if (drawing) begin
      x_hold      <= x_calc;
      y_hold      <= y_calc;
      colour_hold <= pixel_colour;
    end
  end

  assign plot     = drawing;
  assign x        = drawing ? x_calc : x_hold;
  assign y        = drawing ? y_calc : y_hold;
  assign colour   = drawing ? pixel_colour : colour_hold;
  assign mem_rden = (state == S_FETCH);
  assign mem_addr = ADDR_W'(32'(row) * 32'(COLS) + 32'(col));
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_board_renderer.sv
// Bench for board_renderer: default 8x8x16 board plus a 3x2x4 board, checked against a pixel-list model.
// Latency: n/a.
// Backpressure: n/a.
module tb_board_renderer;
  import board_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn;
  logic       d_start;
  logic       s_start;
  logic [7:0] player_x;
  logic [7:0] player_y;
  logic [5:0] player_colour;

  logic       d_busy, d_done, d_rden, d_plot;
  logic [5:0] d_addr;
  logic [2:0] d_q, d_colour;
  logic [8:0] d_x;
  logic [7:0] d_y;

  logic       s_busy, s_done, s_rden, s_plot;
  logic [2:0] s_addr;
  logic [2:0] s_q, s_colour;
  logic [8:0] s_x;
  logic [7:0] s_y;

  board_renderer dut_d (
    .clock(clock), .resetn(resetn), .start(d_start), .busy(d_busy), .done(d_done),
    .mem_addr(d_addr), .mem_rden(d_rden), .mem_q(d_q),
    .player_x(player_x), .player_y(player_y), .player_colour(player_colour),
    .x(d_x), .y(d_y), .colour(d_colour), .plot(d_plot)
  );

  board_renderer #(.COLS(3), .ROWS(2), .TILE(4)) dut_s (
    .clock(clock), .resetn(resetn), .start(s_start), .busy(s_busy), .done(s_done),
    .mem_addr(s_addr), .mem_rden(s_rden), .mem_q(s_q),
    .player_x(player_x), .player_y(player_y), .player_colour(player_colour),
    .x(s_x), .y(s_y), .colour(s_colour), .plot(s_plot)
  );

  // Board memories: one-cycle read latency, garbage on cycles without a read
  logic [2:0] d_mem [64];
  logic [2:0] s_mem [8];
  always @(posedge clock) d_q <= d_rden ? d_mem[d_addr] : 3'($urandom);
  always @(posedge clock) s_q <= s_rden ? s_mem[s_addr] : 3'($urandom);

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor mux: sel=1 watches the small board
  bit         sel = 1'b0;
  logic       m_plot, m_rden, m_done;
  logic [8:0] m_x;
  logic [7:0] m_y;
  logic [2:0] m_c;
  logic [5:0] m_addr;
  assign m_plot = sel ? s_plot : d_plot;
  assign m_rden = sel ? s_rden : d_rden;
  assign m_done = sel ? s_done : d_done;
  assign m_x    = sel ? s_x : d_x;
  assign m_y    = sel ? s_y : d_y;
  assign m_c    = sel ? s_colour : d_colour;
  assign m_addr = sel ? {3'b000, s_addr} : d_addr;

  typedef struct { int x; int y; int c; } pix_t;
  pix_t pix_q[$];
  pix_t exp_q[$];
  int   addr_q[$];
  int   plot_cnt, done_cnt, first_cyc, last_cyc, done_cyc, accept_cyc;
  int   snap_x[2], snap_y[2], snap_c[2];
  int   tests = 0;
  int   fails = 0;

  always @(negedge clock) begin
    if (m_plot) begin
      pix_q.push_back('{int'(m_x), int'(m_y), int'(m_c)});
      if (plot_cnt == 0) first_cyc = cyc;
      last_cyc = cyc;
      plot_cnt++;
    end
    if (m_rden) addr_q.push_back(int'(m_addr));
    if (m_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    pix_q.delete();
    addr_q.delete();
    plot_cnt = 0;
    done_cnt = 0;
    first_cyc = -1;
    last_cyc = -1;
    done_cyc = -1;
  endtask

  task automatic set_players(input int x0, input int y0, input int c0,
                             input int x1, input int y1, input int c1);
    player_x      = {4'(x1), 4'(x0)};
    player_y      = {4'(y1), 4'(y0)};
    player_colour = {3'(c1), 3'(c0)};
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1 clear_mon();
    @(negedge clock);
    if (sel) s_start = 1'b1;
    else     d_start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      snap_x[i] = int'(player_x[i*4 +: 4]);
      snap_y[i] = int'(player_y[i*4 +: 4]);
      snap_c[i] = int'(player_colour[i*3 +: 3]);
    end
    @(negedge clock);
    s_start = 1'b0;
    d_start = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    chk("done_seen", longint'(done_cnt > 0), 1);
  endtask

  // Reference: the full ordered pixel list a frame should produce, built cell by cell
  task automatic build_expected(input int cols, input int rows, input int tile);
    exp_q.delete();
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        int cell_c;
        cell_c = sel ? int'(s_mem[r*cols + c]) : int'(d_mem[r*cols + c]);
        for (int i = 1; i >= 0; i--) begin
          if (snap_x[i] == c && snap_y[i] == r) cell_c = snap_c[i];
        end
        for (int py = 0; py < tile; py++) begin
          for (int px = 0; px < tile; px++) begin
            int pc;
            pc = cell_c;
`ifdef BOARD_GRID_EN
            if (px == 0 || py == 0) pc = int'(GRID_COLOUR);
`endif
            exp_q.push_back('{(32 + c*tile + px) % 512, (8 + r*tile + py) % 256, pc});
          end
        end
      end
    end
  endtask

  task automatic check_frame(input string tag, input int cols, input int rows, input int tile);
    int n;
    int errs;
    n = cols * rows;
    build_expected(cols, rows, tile);
    chk({tag, "_frame_len"}, last_cyc - accept_cyc + 1, n * (tile*tile + 2));
    chk({tag, "_first_plot_cycle"}, first_cyc - accept_cyc + 1, 3);
    chk({tag, "_plot_count"}, plot_cnt, n * tile * tile);
    chk({tag, "_done_count"}, done_cnt, 1);
    chk({tag, "_done_cycle"}, done_cyc, last_cyc + 1);
    errs = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= pix_q.size()) errs++;
      else if (pix_q[i].x != exp_q[i].x || pix_q[i].y != exp_q[i].y || pix_q[i].c != exp_q[i].c) errs++;
    end
    chk({tag, "_pixel_errors"}, errs, 0);
    chk({tag, "_fetch_count"}, addr_q.size(), n);
    errs = 0;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i) errs++;
    chk({tag, "_addr_order_errors"}, errs, 0);
  endtask

  function automatic int count_cell(input int x0, input int y0, input int tile, input int c);
    int k;
    k = 0;
    foreach (pix_q[i]) begin
      if (pix_q[i].x >= x0 && pix_q[i].x < x0 + tile &&
          pix_q[i].y >= y0 && pix_q[i].y < y0 + tile && pix_q[i].c == c) k++;
    end
    return k;
  endfunction

`ifdef BOARD_GRID_EN
  localparam int FULL_CELL = 225;
`else
  localparam int FULL_CELL = 256;
`endif

  initial begin
    resetn  = 1'b0;
    d_start = 1'b0;
    s_start = 1'b0;
    set_players(15, 15, WHITE, 15, 15, WHITE);
    for (int i = 0; i < 64; i++) d_mem[i] = 3'(i);
    for (int i = 0; i < 8; i++)  s_mem[i] = 3'(i);
    clear_mon();

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_busy", d_busy, 0);
    chk("rst_done", d_done, 0);
    chk("rst_plot", d_plot, 0);
    chk("rst_rden", d_rden, 0);
    chk("rst_addr", d_addr, 0);
    chk("rst_x", d_x, 0);
    chk("rst_y", d_y, 0);
    chk("rst_colour", d_colour, 0);
    chk("rst_small_busy", s_busy, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    // Frame A: colour = addr[2:0], players off the board
    sel = 1'b0;
    pulse_start();
    chk("A_busy_after_accept", d_busy, 1);
    wait_done(17000);
    check_frame("A", 8, 8, 16);
    chk("A_first_x", pix_q.size() > 0 ? pix_q[0].x : -1, 32);
    chk("A_first_y", pix_q.size() > 0 ? pix_q[0].y : -1, 8);
    chk("A_idle_busy", d_busy, 0);

    // Frame B: random board, player0 (1,1) red, player1 (4,3) blue
    for (int i = 0; i < 64; i++) d_mem[i] = 3'($urandom);
    set_players(1, 1, RED, 4, 3, BLUE);
    pulse_start();
    wait_done(17000);
    check_frame("B", 8, 8, 16);
    chk("B_cell9_red", count_cell(32 + 16, 8 + 16, 16, RED), FULL_CELL);
    chk("B_cell28_blue", count_cell(32 + 64, 8 + 48, 16, BLUE), FULL_CELL);

    // Frame C: both players on (2,2); re-pulse start and move players mid-frame
    for (int i = 0; i < 64; i++) d_mem[i] = 3'($urandom);
    set_players(2, 2, RED, 2, 2, BLUE);
    pulse_start();
    repeat (98) @(negedge clock);
    d_start = 1'b1;
    set_players($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
    @(negedge clock);
    d_start = 1'b0;
    wait_done(17000);
    check_frame("C", 8, 8, 16);
    chk("C_cell18_player0", count_cell(32 + 32, 8 + 32, 16, RED), FULL_CELL);

    // Reset in the middle of a frame, then silence until a new start
    pulse_start();
    repeat (4999) @(negedge clock);
    chk("mid_busy_before_rst", d_busy, 1);
    chk("mid_plot_before_rst", d_plot, 1);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_plot", d_plot, 0);
    chk("mid_rst_busy", d_busy, 0);
    chk("mid_rst_rden", d_rden, 0);
    chk("mid_rst_x", d_x, 0);
    chk("mid_rst_addr", d_addr, 0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1 clear_mon();
    repeat (1000) @(negedge clock);
    chk("post_rst_plots", plot_cnt, 0);
    chk("post_rst_done", done_cnt, 0);
    chk("post_rst_busy", d_busy, 0);

    // Small board, randomized frames including off-board players
    sel = 1'b1;
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 6; i++) s_mem[i] = 3'($urandom);
      set_players($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 7),
                  $urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 7));
      pulse_start();
      wait_done(300);
      check_frame("S", 3, 2, 4);
      chk("S_last_x", pix_q.size() > 0 ? pix_q[pix_q.size()-1].x : -1, 32 + 11);
      chk("S_last_y", pix_q.size() > 0 ? pix_q[pix_q.size()-1].y : -1, 8 + 7);
      repeat (int'($urandom_range(0, 5))) @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/board_renderer.md
BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 SHALL have parameter COLS, default 8, meaning board columns (1..16).
REQ-002 SHALL have parameter ROWS, default 8, meaning board rows (1..16).
REQ-003 SHALL have parameter TILE, default 16, meaning tile edge in pixels (power of 2, 2..32).
REQ-004 SHALL have parameters X_ORIGIN (default 32) and Y_ORIGIN (default 8), meaning the screen pixel of the top-left corner of cell (0,0).
REQ-005 SHALL have parameter NUM_PLAYERS, default 2, meaning the number of overlay markers (1..4).
REQ-006 SHALL have parameters COLOUR_W (default 3), X_W (default 9) and Y_W (default 8), meaning the widths of colour, x and y.
REQ-007 SHALL have ports: clock in 1 = system clock; resetn in 1 = asynchronous active-low reset.
REQ-008 SHALL have ports: start in 1 = frame request pulse; busy out 1 = frame in progress; done out 1 = single-cycle end-of-frame pulse.
REQ-009 SHALL have ports: mem_addr out ADDR_W = cell address; mem_rden out 1 = read strobe; mem_q in COLOUR_W = cell colour, valid exactly 1 cycle after mem_rden.
REQ-010 SHALL have ports: player_x in 4*NUM_PLAYERS and player_y in 4*NUM_PLAYERS = packed cell coordinates; player_colour in COLOUR_W*NUM_PLAYERS = packed marker colours.
REQ-011 SHALL have ports: x out X_W, y out Y_W, colour out COLOUR_W, plot out 1, all driving the VGA adapter.

Function
REQ-012 SHALL run the FSM IDLE -> FETCH -> WAIT -> DRAW -> (FETCH for the next cell | DONE) -> IDLE.
REQ-013 SHALL accept start only in IDLE; start while busy SHALL be ignored, not queued.
REQ-014 SHALL snapshot player_x, player_y and player_colour in the cycle start is accepted; later input changes SHALL NOT affect the current frame.
REQ-015 SHALL scan cells row-major, col fastest, with mem_addr = row*COLS + col and ADDR_W = clog2(COLS*ROWS) (minimum 1).
REQ-016 FETCH SHALL last 1 cycle with mem_rden=1; WAIT SHALL last 1 cycle and register mem_q; mem_rden SHALL be 0 in all other states.
REQ-017 DRAW SHALL last TILE*TILE cycles with plot=1 every cycle, scanning px fastest, then py.
REQ-018 In DRAW, x SHALL equal X_ORIGIN + col*TILE + px and y SHALL equal Y_ORIGIN + row*TILE + py, truncated to X_W/Y_W.
REQ-019 Tile colour SHALL be the registered mem_q, overridden by player_colour[i] of the lowest index i whose snapshot (x,y) equals (col,row).
REQ-020 Player coordinates with x>=COLS or y>=ROWS SHALL produce no overlay.
REQ-021 Frame length SHALL be COLS*ROWS*(TILE*TILE+2) cycles from start acceptance to the last plot.
REQ-022 done SHALL pulse 1 cycle in DONE, the cycle after the last plot; busy SHALL be high from the cycle after start acceptance through DONE inclusive.
REQ-023 Outside DRAW, plot SHALL be 0, and x, y and colour SHALL hold their last values.

Reset
REQ-024 While resetn=0, the FSM SHALL be in IDLE and busy, done, plot, mem_rden, mem_addr, x, y, colour and all counters and snapshots SHALL be 0, asynchronously, including mid-frame.
REQ-025 After resetn rises, a new start SHALL be required; an aborted frame SHALL NOT resume.

Configuration
REQ-026 With macro BOARD_GRID_EN defined, pixels with px==0 or py==0 SHALL use colour GRID_COLOUR (package constant, black), taking priority over the player overlay.
REQ-027 Without BOARD_GRID_EN, every tile pixel SHALL use the colour from REQ-019; timing SHALL be identical in both builds.

Structure
REQ-028 The shared package board_pkg SHALL hold the FSM state enum, the colour constants (GRID_COLOUR, WHITE, RED, BLUE) and the coordinate nibble width (4).
REQ-029 Pixel/cell scanning SHALL be one sub-module, tile_counter (px, py, col, row counters with wrap and last flags); the FSM and overlay logic SHALL stay in board_renderer.

Verification
REQ-030 Defaults, memory holds colour = addr[2:0], no players on board (x=15), start pulse -> 64*258 = 16512 cycles to the last plot, 16384 plot cycles, done 1 cycle later, first pixel (32,8).
REQ-031 Player0 at (1,1) red, player1 at (4,3) blue -> all 256 pixels of cell 9 are red and all of cell 28 are blue; both players at (2,2) -> cell 18 is player0's colour.
REQ-032 start re-pulsed at cycle 100 of a frame -> ignored; single done; frame length unchanged; player inputs changed mid-frame -> no effect.
REQ-033 resetn low at cycle 5000 -> plot, busy and mem_rden are 0 immediately; after release with no start, no plot for 1000 cycles.
REQ-034 COLS=3, ROWS=2, TILE=4 -> 6*18 = 108 cycles; last plotted pixel (32+11, 8+7); mem_addr sequence 0..5.
REQ-035 BOARD_GRID_EN build, player0 at (0,0) -> pixels (32..47,8) and (32,8..23) are GRID_COLOUR, pixel (33,9) is player0's colour.
